// File: rtl/hdmi_blk_scheduler.sv
// Block-stream scheduler feeding the block-to-HDMI stripe converter.
// Credit-paced per stripe, generates sof/sob/eob framing and resync/credit errors.

module hdmi_blk_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] y,
  input  logic [7:0] cr,
  input  logic [7:0] cb,
  output logic [7:0] q_y,
  output logic [7:0] q_cr,
  output logic [7:0] q_cb
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_y  <= '0;
      q_cr <= '0;
      q_cb <= '0;
    end else if (load) begin
      q_y  <= y;
      q_cr <= cr;
      q_cb <= cb;
    end
  end
endmodule

module hdmi_blk_scheduler #(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           src_valid,
  output logic           src_ready,
  input  logic           src_sof,
  input  logic [N*8-1:0] src_data_y,
  input  logic [N*8-1:0] src_data_cr,
  input  logic [N*8-1:0] src_data_cb,
  input  logic           bank_free,
  output logic           out_valid,
  output logic [N*8-1:0] out_data_y,
  output logic [N*8-1:0] out_data_cr,
  output logic [N*8-1:0] out_data_cb,
  output logic           out_sof,
  output logic           out_sob,
  output logic           out_eob,
  output logic [1:0]     credits,
  output logic           frame_done,
  output logic           err_resync,
  output logic           err_credit
);
  localparam int BPB = 64 / N;
  localparam int BPS = X_RES / 8;
  localparam int STR = Y_RES / 8;
  localparam int BW  = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int KW  = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int SW  = (STR > 1) ? $clog2(STR) : 1;

  typedef enum logic [1:0] {S_WAIT_SOF, S_STREAM, S_WAIT_CREDIT} state_t;
  typedef struct packed {
    logic sof;
    logic sob;
    logic eob;
  } mark_t;

  state_t        state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic [KW-1:0] blk, blk_n;
  logic [SW-1:0] stripe, stripe_n;
  logic          acc, fwd, consume, resync, done, inc;
  logic          last_beat, last_blk, last_str;
  logic [1:0]    credits_n;
  mark_t         mark_d, mark_q;

  assign last_beat = (beat == BW'(BPB - 1));
  assign last_blk  = (blk == KW'(BPS - 1));
  assign last_str  = (stripe == SW'(STR - 1));

  // In WAIT_CREDIT a bank freed this very cycle already unblocks the stripe.
  always_comb begin
    src_ready = 1'b0;
    case (state)
      S_WAIT_SOF:    src_ready = enable && (!src_sof || credits != 2'd0);
      S_STREAM:      src_ready = !src_sof || credits != 2'd0;
      S_WAIT_CREDIT: src_ready = (credits != 2'd0) || bank_free;
      default:       src_ready = 1'b0;
    endcase
  end

  assign acc = src_valid && src_ready;

  always_comb begin
    state_n  = state;
    beat_n   = beat;
    blk_n    = blk;
    stripe_n = stripe;
    fwd      = 1'b0;
    consume  = 1'b0;
    resync   = 1'b0;
    done     = 1'b0;
    case (state)
      S_WAIT_SOF: begin
        if (acc && src_sof) begin
          fwd     = 1'b1;
          consume = 1'b1;
          beat_n  = BW'(1);
          state_n = S_STREAM;
        end
      end
      default: begin
        if (acc) begin
          fwd = 1'b1;
          if (src_sof) begin
            resync   = 1'b1;
            consume  = 1'b1;
            beat_n   = BW'(1);
            blk_n    = '0;
            stripe_n = '0;
            state_n  = S_STREAM;
          end else begin
            consume = (state == S_WAIT_CREDIT);
            state_n = S_STREAM;
            if (last_beat) begin
              beat_n = '0;
              if (last_blk) begin
                blk_n = '0;
                if (last_str) begin
                  stripe_n = '0;
                  done     = 1'b1;
                  state_n  = S_WAIT_SOF;
                end else begin
                  stripe_n = stripe + 1'b1;
                  state_n  = S_WAIT_CREDIT;
                end
              end else begin
                blk_n = blk + 1'b1;
              end
            end else begin
              beat_n = beat + 1'b1;
            end
          end
        end
      end
    endcase
  end

  // A resync beat restarts the counters, so it is a block start, never a block end.
  always_comb begin
    mark_d.sof = fwd && src_sof;
    mark_d.sob = fwd && (resync || beat == '0);
    mark_d.eob = fwd && !resync && last_beat;
  end

  assign inc       = bank_free && (credits != 2'd2);
  assign credits_n = credits + {1'b0, inc} - {1'b0, consume};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT_SOF;
      beat       <= '0;
      blk        <= '0;
      stripe     <= '0;
      credits    <= 2'd2;
      out_valid  <= 1'b0;
      mark_q     <= '0;
      frame_done <= 1'b0;
      err_resync <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      blk        <= blk_n;
      stripe     <= stripe_n;
      credits    <= credits_n;
      out_valid  <= fwd;
      mark_q     <= mark_d;
      frame_done <= done;
      err_resync <= resync;
      err_credit <= bank_free && (credits == 2'd2);
    end
  end

  assign out_sof = mark_q.sof;
  assign out_sob = mark_q.sob;
  assign out_eob = mark_q.eob;

  for (genvar l = 0; l < N; l++) begin : g_lane
    hdmi_blk_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (fwd),
      .y    (src_data_y[l*8 +: 8]),
      .cr   (src_data_cr[l*8 +: 8]),
      .cb   (src_data_cb[l*8 +: 8]),
      .q_y  (out_data_y[l*8 +: 8]),
      .q_cr (out_data_cr[l*8 +: 8]),
      .q_cb (out_data_cb[l*8 +: 8])
    );
  end
endmodule

// File: tb/tb_hdmi_blk_scheduler.sv
// Directed bench for hdmi_blk_scheduler with a 16x16 frame (32 beats/block, 2 blocks/stripe, 2 stripes).
module tb_hdmi_blk_scheduler;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n, enable, src_valid, src_sof, bank_free;
  logic           src_ready, out_valid, out_sof, out_sob, out_eob;
  logic           frame_done, err_resync, err_credit;
  logic [N*8-1:0] src_data_y, src_data_cr, src_data_cb;
  logic [N*8-1:0] out_data_y, out_data_cr, out_data_cb;
  logic [1:0]     credits;

  hdmi_blk_scheduler #(.N(N), .X_RES(16), .Y_RES(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .src_valid(src_valid),
    .src_ready(src_ready), .src_sof(src_sof), .src_data_y(src_data_y),
    .src_data_cr(src_data_cr), .src_data_cb(src_data_cb), .bank_free(bank_free),
    .out_valid(out_valid), .out_data_y(out_data_y), .out_data_cr(out_data_cr),
    .out_data_cb(out_data_cb), .out_sof(out_sof), .out_sob(out_sob),
    .out_eob(out_eob), .credits(credits), .frame_done(frame_done),
    .err_resync(err_resync), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output log, one entry per out_valid beat.
  int          out_cnt = 0;
  int          fd_cnt = 0, rs_cnt = 0, ec_cnt = 0;
  bit          m_sof[2048], m_sob[2048], m_eob[2048], m_fd[2048], m_rs[2048];
  logic [15:0] m_y[2048];

  always @(negedge clk) begin
    if (out_valid && out_cnt < 2048) begin
      m_sof[out_cnt] <= out_sof;
      m_sob[out_cnt] <= out_sob;
      m_eob[out_cnt] <= out_eob;
      m_fd[out_cnt]  <= frame_done;
      m_rs[out_cnt]  <= err_resync;
      m_y[out_cnt]   <= out_data_y;
      out_cnt        <= out_cnt + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (err_resync) rs_cnt <= rs_cnt + 1;
    if (err_credit) ec_cnt <= ec_cnt + 1;
  end

  typedef struct {
    int idx;
    bit sof, sob, eob, fd;
  } mvec_t;
  mvec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts and ends 1 time unit after a falling edge; leaves src_valid high.
  task automatic send(input bit sof, input logic [7:0] tag, input bit bf, output bit ok);
    ok          = 1'b0;
    src_valid   = 1'b1;
    src_sof     = sof;
    bank_free   = bf;
    src_data_y  = {tag, tag};
    src_data_cr = {~tag, ~tag};
    src_data_cb = {tag + 8'd1, tag};
    for (int t = 0; t < 300; t++) begin
      #1;
      if (src_ready) begin
        ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        break;
      end
      @(negedge clk);
      #1;
    end
    bank_free = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no src_ready expected src_ready within 300 cycles (tag %0d)", tag);
    end
  endtask

  task automatic send_run(input int first, input int count, input bit sof_first);
    bit ok;
    for (int i = 0; i < count; i++) send(sof_first && i == 0, 8'(first + i), 1'b0, ok);
  endtask

  task automatic idle(input int n);
    src_valid = 1'b0;
    src_sof   = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_bf();
    bank_free = 1'b1;
    @(negedge clk);
    #1;
    bank_free = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fd0, rs0, ec0, cnt_sof, cnt_sob, cnt_eob, nacc;
    bit ok;

    tbl[0] = '{0,   1, 1, 0, 0};
    tbl[1] = '{1,   0, 0, 0, 0};
    tbl[2] = '{31,  0, 0, 1, 0};
    tbl[3] = '{32,  0, 1, 0, 0};
    tbl[4] = '{63,  0, 0, 1, 0};
    tbl[5] = '{64,  0, 1, 0, 0};
    tbl[6] = '{95,  0, 0, 1, 0};
    tbl[7] = '{96,  0, 1, 0, 0};
    tbl[8] = '{100, 0, 0, 0, 0};
    tbl[9] = '{127, 0, 0, 1, 1};

    rst_n = 1'b0; enable = 1'b0; src_valid = 1'b0; src_sof = 1'b0; bank_free = 1'b0;
    src_data_y = '0; src_data_cr = '0; src_data_cb = '0;
    @(negedge clk);
    #1;
    chk("reset_credits", credits, 2);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_src_ready_disabled", src_ready, 0);
    rst_n = 1'b1;
    idle(1);

    // Frame 1: continuous 128 beats.
    enable = 1'b1;
    base = out_cnt; fd0 = fd_cnt;
    send_run(0, 128, 1'b1);
    idle(2);
    chk("f1_beats", out_cnt - base, 128);
    chk("f1_credits_end", credits, 0);
    chk("f1_frame_done_count", fd_cnt - fd0, 1);
    foreach (tbl[k]) begin
      chk($sformatf("f1_markers_beat%0d", tbl[k].idx),
          {m_sof[base+tbl[k].idx], m_sob[base+tbl[k].idx], m_eob[base+tbl[k].idx], m_fd[base+tbl[k].idx]},
          {tbl[k].sof, tbl[k].sob, tbl[k].eob, tbl[k].fd});
    end
    cnt_sof = 0; cnt_sob = 0; cnt_eob = 0;
    for (int i = 0; i < 128; i++) begin
      cnt_sof += int'(m_sof[base+i]);
      cnt_sob += int'(m_sob[base+i]);
      cnt_eob += int'(m_eob[base+i]);
    end
    chk("f1_sof_count", cnt_sof, 1);
    chk("f1_sob_count", cnt_sob, 4);
    chk("f1_eob_count", cnt_eob, 4);
    chk("f1_data_beat70", m_y[base+70], 16'h4646);

    // Frame 2: sof stalls with no credits until a bank drains.
    src_sof = 1'b1;
    #1;
    chk("f2_sof_stalled", src_ready, 0);
    src_sof = 1'b0;
    pulse_bf();
    chk("f2_credit_after_free", credits, 1);
    base = out_cnt; fd0 = fd_cnt; ec0 = ec_cnt;
    send(1'b1, 8'd0, 1'b0, ok);
    chk("f2_credit_after_sof", credits, 0);
    send_run(1, 63, 1'b0);
    idle(1);
    src_valid = 1'b1;
    #1;
    chk("f2_wait_credit_stall", src_ready, 0);
    idle(1);
    pulse_bf();
    chk("f2_credit_before_stripe1", credits, 1);
    send(1'b0, 8'd64, 1'b1, ok);
    chk("f3_free_and_consume", credits, 1);
    send_run(65, 63, 1'b0);
    idle(2);
    chk("f2_beats", out_cnt - base, 128);
    chk("f2_frame_done_count", fd_cnt - fd0, 1);
    chk("f3_no_err_credit", ec_cnt - ec0, 0);

    // Freeing a bank when both are already free.
    pulse_bf();
    chk("f3_credits_full", credits, 2);
    chk("f3_err_credit_quiet", err_credit, 0);
    pulse_bf();
    chk("f3_err_credit_pulse", err_credit, 1);
    chk("f3_credits_saturated", credits, 2);

    // Frame 3: resync at beat 40.
    base = out_cnt; fd0 = fd_cnt; rs0 = rs_cnt;
    send_run(0, 40, 1'b1);
    send(1'b1, 8'd40, 1'b0, ok);
    idle(1);
    chk("f4_credits_after_resync", credits, 0);
    pulse_bf();
    send_run(41, 127, 1'b0);
    idle(2);
    chk("f4_resync_count", rs_cnt - rs0, 1);
    chk("f4_resync_flags", {m_sof[base+40], m_sob[base+40], m_eob[base+40], m_rs[base+40]}, 4'b1101);
    chk("f4_eob_after_resync", m_eob[base+40+31], 1);
    chk("f4_frame_done_pos", m_fd[base+40+127], 1);
    chk("f4_no_early_done", m_fd[base+40+126], 0);
    chk("f4_frame_done_count", fd_cnt - fd0, 1);
    chk("f4_beats", out_cnt - base, 168);
    chk("f4_credits_end", credits, 0);

    // Non-sof beats in WAIT_SOF are swallowed.
    base = out_cnt; nacc = 0;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 8'(200 + i), 1'b0, ok);
      nacc += int'(ok);
    end
    idle(2);
    chk("f5_discard_accepted", nacc, 5);
    chk("f5_discard_no_output", out_cnt - base, 0);
    chk("f5_credits_unchanged", credits, 0);
    enable = 1'b0;
    src_valid = 1'b1;
    #1;
    chk("f5_disabled_ready", src_ready, 0);
    enable = 1'b1;
    #1;
    chk("f5_enabled_nonsof_ready", src_ready, 1);
    src_sof = 1'b1;
    #1;
    chk("f5_sof_no_credit_ready", src_ready, 0);
    src_valid = 1'b0;
    src_sof = 1'b0;
    @(negedge clk);
    #1;

    // Reset in the middle of a stripe, then a clean frame.
    pulse_bf();
    pulse_bf();
    send_run(0, 20, 1'b1);
    chk("f6_streaming_before_reset", out_valid, 1);
    src_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("f6_async_out_valid", out_valid, 0);
    chk("f6_async_sob", out_sob, 0);
    chk("f6_async_credits", credits, 2);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    base = out_cnt; fd0 = fd_cnt;
    send_run(0, 128, 1'b1);
    idle(2);
    chk("f6_beats", out_cnt - base, 128);
    chk("f6_first_markers", {m_sof[base], m_sob[base], m_eob[base]}, 3'b110);
    chk("f6_last_markers", {m_eob[base+127], m_fd[base+127]}, 2'b11);
    chk("f6_frame_done_count", fd_cnt - fd0, 1);
    chk("f6_credits_end", credits, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
